// File: rtl/bcd_countdown_timer_if.sv
// Control/status bundle for the BCD timer: preset/mode/load/button in, packed count and status out.
interface bcd_countdown_timer_if #(
  parameter int DIGITS = 2
);
  logic                  load;
  logic [4*DIGITS-1:0]   preset;
  logic                  mode;
  logic                  start_n;
  logic [4*DIGITS-1:0]   count;
  logic                  running;
  logic                  done;
  logic                  expired;

  modport master (output load, preset, mode, start_n,
                  input  count, running, done, expired);
  modport slave  (input  load, preset, mode, start_n,
                  output count, running, done, expired);
endinterface

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD down/up timer with prescaled tick, run/pause button and done/expired status.
module bcd_countdown_timer #(
  parameter int DIGITS  = 2,
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 1
) (
  input  logic                   clkin,
  input  logic                   reset,
  bcd_countdown_timer_if.slave   bus
);
  localparam int W   = 4*DIGITS;
  localparam int DIV = CLK_HZ/TICK_HZ;
  localparam int PW  = $clog2(DIV);
  localparam logic [PW-1:0] DIV_M1 = PW'(DIV-1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] PAUSED = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  function automatic logic [W-1:0] sanit(input logic [W-1:0] p);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < DIGITS; k++)
      r[4*k +: 4] = (p[4*k +: 4] > 4'd9) ? 4'd9 : p[4*k +: 4];
    return r;
  endfunction

  // Ripple one BCD step from digit 0; carry/borrow continues only through 9s/0s.
  function automatic logic [W-1:0] bcd_step(input logic [W-1:0] v, input logic up);
    logic [W-1:0] r;
    logic         c;
    logic [3:0]   d;
    r = v;
    c = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      d = v[4*k +: 4];
      if (c) begin
        if (up) begin
          if (d == 4'd9) r[4*k +: 4] = 4'd0;
          else begin r[4*k +: 4] = d + 4'd1; c = 1'b0; end
        end else begin
          if (d == 4'd0) r[4*k +: 4] = 4'd9;
          else begin r[4*k +: 4] = d - 4'd1; c = 1'b0; end
        end
      end
    end
    return r;
  endfunction

  logic [1:0]    state, state_n;
  logic [W-1:0]  cnt, cnt_n, target, end_val, stepped;
  logic [PW-1:0] presc, presc_n;
  logic          mode_q, exp_q, exp_n, tick;
  logic          s1, s2, s3, press;
  logic [1:0]    sv;

  // s3 only takes real samples once s2 holds a post-reset pin value, so a button
  // held low through reset cannot look like a fresh falling edge.
  always_ff @(posedge clkin) begin
    if (!reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b0;
      sv <= 2'b00;
    end else begin
      s1 <= bus.start_n;
      s2 <= s1;
      s3 <= sv[1] ? s2 : 1'b0;
      sv <= {sv[0], 1'b1};
    end
  end

  assign press = s3 & ~s2;

  always_comb begin
    tick    = (state == RUN) && (presc == DIV_M1);
    end_val = mode_q ? target : '0;
    stepped = bcd_step(cnt, mode_q);
    state_n = state;
    cnt_n   = cnt;
    presc_n = presc;
    exp_n   = 1'b0;
    case (state)
      IDLE: if (press) begin
        if (cnt == end_val) begin
          state_n = DONE;
          exp_n   = 1'b1;
          presc_n = '0;
        end else state_n = RUN;
      end
      RUN: begin
        presc_n = tick ? '0 : presc + 1'b1;
        if (tick) cnt_n = stepped;
        if (tick && stepped == end_val) begin
          state_n = DONE;
          exp_n   = 1'b1;
          presc_n = '0;
        end else if (press) state_n = PAUSED;
      end
      PAUSED: if (press) state_n = RUN;
      DONE:    presc_n = '0;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clkin) begin
    if (!reset || bus.load) begin
      state  <= IDLE;
      presc  <= '0;
      exp_q  <= 1'b0;
      mode_q <= bus.mode;
      target <= sanit(bus.preset);
      cnt    <= bus.mode ? '0 : sanit(bus.preset);
    end else begin
      state  <= state_n;
      presc  <= presc_n;
      exp_q  <= exp_n;
      cnt    <= cnt_n;
    end
  end

  assign bus.count   = cnt;
  assign bus.running = (state == RUN);
  assign bus.done    = (state == DONE);
  assign bus.expired = exp_q;
endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Randomised + directed bench for bcd_countdown_timer against a decimal-arithmetic reference model.
module tb_bcd_countdown_timer;
  localparam int DIGITS = 2;
  localparam int DIV    = 10;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  logic clkin = 1'b0;
  logic reset = 1'b0;
  always #5 clkin = ~clkin;

  bcd_countdown_timer_if #(.DIGITS(DIGITS)) bus();

  bcd_countdown_timer #(.DIGITS(DIGITS), .CLK_HZ(10), .TICK_HZ(1)) dut (
    .clkin (clkin),
    .reset (reset),
    .bus   (bus)
  );

  int errs = 0;
  int checks = 0;
  bit chk_en = 0;

  // Reference model: count kept as a plain decimal integer, prescaler as a phase 0..DIV-1.
  int m_st, m_cnt, m_tgt, m_ph;
  bit m_mode, m_exp;
  int p1, p2, p3;   // pin samples from 1/2/3 edges ago, -1 = not sampled since reset

  function automatic int san(input logic [4*DIGITS-1:0] p);
    int v, mul, d;
    v = 0; mul = 1;
    for (int k = 0; k < DIGITS; k++) begin
      d = int'(p[4*k +: 4]);
      if (d > 9) d = 9;
      v += d*mul;
      mul *= 10;
    end
    return v;
  endfunction

  function automatic logic [4*DIGITS-1:0] bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int t;
    r = '0; t = v;
    for (int k = 0; k < DIGITS; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clkin) begin : model
    bit press;
    int endv;
    if (!reset || (reset && bus.load)) begin
      if (!reset) begin p1 = -1; p2 = -1; p3 = -1; end
      else begin p3 = p2; p2 = p1; p1 = int'(bus.start_n); end
      m_st = M_IDLE; m_ph = 0; m_exp = 0;
      m_mode = bus.mode;
      m_tgt = san(bus.preset);
      m_cnt = bus.mode ? 0 : m_tgt;
    end else begin
      press = (p2 == 0 && p3 == 1);
      p3 = p2; p2 = p1; p1 = int'(bus.start_n);
      m_exp = 0;
      endv = m_mode ? m_tgt : 0;
      case (m_st)
        M_IDLE: if (press) begin
          if (m_cnt == endv) begin m_st = M_DONE; m_exp = 1; m_ph = 0; end
          else m_st = M_RUN;
        end
        M_RUN: begin
          if (m_ph == DIV-1) begin
            m_ph = 0;
            m_cnt = m_mode ? m_cnt + 1 : m_cnt - 1;
            if (m_cnt == endv) begin m_st = M_DONE; m_exp = 1; end
            else if (press) m_st = M_PAUSE;
          end else begin
            m_ph++;
            if (press) m_st = M_PAUSE;
          end
        end
        M_PAUSE: if (press) m_st = M_RUN;
        default: ;
      endcase
    end
  end

  always @(negedge clkin) begin
    if (chk_en) begin
      chk("count",   32'(bus.count), 32'(bcd(m_cnt)));
      chk("running", 32'(bus.running), 32'(m_st == M_RUN));
      chk("done",    32'(bus.done), 32'(m_st == M_DONE));
      chk("expired", 32'(bus.expired), 32'(m_exp));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clkin);
  endtask

  task automatic press_btn();
    bus.start_n = 1'b0;
    cyc(1);
    bus.start_n = 1'b1;
  endtask

  task automatic do_load(input logic [7:0] p, input logic m);
    bus.preset = p; bus.mode = m; bus.load = 1'b1;
    cyc(1);
    bus.load = 1'b0;
  endtask

  initial begin
    bit seen;
    bus.load = 1'b0; bus.preset = 8'h10; bus.mode = 1'b0; bus.start_n = 1'b1;
    reset = 1'b0;
    cyc(1);
    reset = 1'b1;
    chk_en = 1;
    chk("rst_count", 32'(bus.count), 32'h10);
    chk("rst_running", 32'(bus.running), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_expired", 32'(bus.expired), 0);
    cyc(4);

    // down count with borrow
    press_btn();
    cyc(1); chk("lat_not_yet", 32'(bus.running), 0);
    cyc(1); chk("lat_running", 32'(bus.running), 1);
    cyc(10); chk("borrow_09", 32'(bus.count), 32'h09);
    chk("model_09", 32'(m_cnt), 9);
    cyc(10); chk("step_08", 32'(bus.count), 32'h08);

    // expiry
    do_load(8'h02, 1'b0);
    chk("load_02", 32'(bus.count), 32'h02);
    cyc(3); press_btn(); cyc(2);
    cyc(10); chk("exp_01", 32'(bus.count), 32'h01);
    cyc(9);  chk("exp_pre", 32'(bus.expired), 0);
    cyc(1);  chk("exp_00", 32'(bus.count), 32'h00);
    chk("exp_pulse", 32'(bus.expired), 1);
    chk("exp_done", 32'(bus.done), 1);
    cyc(1);  chk("exp_once", 32'(bus.expired), 0);
    cyc(3); press_btn(); cyc(12);
    chk("done_hold", 32'(bus.done), 1);
    chk("done_cnt", 32'(bus.count), 32'h00);

    // pause / resume keeps prescaler phase
    do_load(8'h05, 1'b0);
    cyc(3); press_btn(); cyc(2);
    cyc(1); press_btn(); cyc(2);
    chk("paused", 32'(bus.running), 0);
    cyc(50); chk("pause_cnt", 32'(bus.count), 32'h05);
    press_btn(); cyc(2);
    chk("resumed", 32'(bus.running), 1);
    cyc(5); chk("phase_pre", 32'(bus.count), 32'h05);
    cyc(1); chk("phase_tick", 32'(bus.count), 32'h04);

    // up mode
    do_load(8'h12, 1'b1);
    chk("up_zero", 32'(bus.count), 32'h00);
    cyc(3); press_btn();
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      cyc(1);
      if (bus.done) seen = 1;
    end
    chk("up_done_seen", 32'(seen), 1);
    chk("up_final", 32'(bus.count), 32'h12);
    chk("up_expired", 32'(bus.expired), 1);

    // clamp and load-over-press priority
    do_load(8'h3C, 1'b0);
    chk("clamp_39", 32'(bus.count), 32'h39);
    cyc(3); press_btn(); cyc(1);
    bus.load = 1'b1; cyc(1); bus.load = 1'b0;
    chk("load_prio", 32'(bus.running), 0);
    cyc(3); chk("load_prio2", 32'(bus.running), 0);

    // reset mid-run with button held through reset
    do_load(8'h08, 1'b0);
    cyc(3); press_btn(); cyc(2);
    cyc(10); chk("mid_07", 32'(bus.count), 32'h07);
    cyc(3);
    bus.start_n = 1'b0; reset = 1'b0; cyc(1); reset = 1'b1;
    chk("rst_mid_cnt", 32'(bus.count), 32'h08);
    chk("rst_mid_run", 32'(bus.running), 0);
    chk("rst_mid_exp", 32'(bus.expired), 0);
    cyc(30); chk("held_no_press", 32'(bus.running), 0);
    bus.start_n = 1'b1; cyc(4);
    press_btn(); cyc(2);
    chk("repress_run", 32'(bus.running), 1);

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(0, 999);
      reset = (r < 3) ? 1'b0 : 1'b1;
      if (r >= 3 && r < 10) begin
        bus.load = 1'b1;
        bus.preset = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 255));
      end else bus.load = 1'b0;
      if ($urandom_range(0, 15) == 0) bus.mode = ~bus.mode;
      if ($urandom_range(0, 7) == 0) bus.start_n = ~bus.start_n;
      cyc(1);
    end
    reset = 1'b1; bus.load = 1'b0;
    cyc(2);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
- Parametrised multi-digit BCD timer for the board's 7-segment display path. It counts down from a preset to zero, or up from zero to a preset.
- A prescaler divides the 50 MHz board clock to a count tick. A single button toggles run/pause. Status outputs report running, done and expiry.
- Outputs are packed BCD digits. The existing hex decoder instances handle the 7-segment conversion externally, one per digit.

Parameters:
- DIGITS, 2, number of BCD digits (1..8); digit 0 is least significant.
- CLK_HZ, 50000000, input clock frequency in Hz.
- TICK_HZ, 1, count rate in Hz; DIV = CLK_HZ/TICK_HZ (integer, ≥2); prescaler width = clog2(DIV).

Ports:
- clkin  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset.
- load  input  1  active-high; sampled each cycle; loads the count from preset per mode.
- preset  input  4*DIGITS  packed BCD preset/target; digit k = preset[4k+3:4k].
- mode  input  1  0 = count down to zero; 1 = count up from zero to preset; sampled only on reset/load.
- start_n  input  1  raw active-low push-button; asynchronous to clkin.
- count  output  4*DIGITS  current packed BCD value.
- running  output  1  high in RUN state.
- done  output  1  high in DONE state.
- expired  output  1  one-cycle pulse on entry to DONE.

Behaviour:
- Reset (reset==0 at posedge):
  - State goes to IDLE, prescaler to 0, expired to 0, and start_n synchroniser flops to 1.
  - mode is latched. count = sanitised preset (mode 0) or all zeros (mode 1). target = sanitised preset.
- Sanitising: any preset digit >9 is clamped to 9, applied at load/reset time.
- Button path:
  - 2-flop synchroniser, then falling-edge detect gives one `press` pulse per high→low transition.
  - Latency is 3 clkin edges from the pin falling to the state change.
  - A held button produces exactly one press.
- Priority per cycle: reset > load > press > tick.
- load=1: same effect as reset on count, target, mode latch, state (IDLE), prescaler and expired; synchroniser is untouched.
- States:
  - IDLE: count frozen. On press: if count==end value → DONE (expired pulses), else → RUN. The end value is 0 in mode 0 and target in mode 1.
  - RUN:
    - Prescaler increments each cycle and wraps at DIV-1. A tick is asserted in the cycle the prescaler equals DIV-1.
    - On a tick, count steps by one in BCD. If the new value equals the end value → DONE with expired=1 for that one cycle.
    - On press → PAUSED; a tick in the same cycle is applied first, and if it reaches the end value DONE wins.
  - PAUSED: prescaler and count hold their values. On press → RUN, and the prescaler resumes from its held value (no phase reset).
  - DONE: count holds the end value, prescaler holds at 0, presses are ignored. Only load or reset leaves DONE.
- BCD arithmetic:
  - Down: decrement digit 0. A digit at 0 becomes 9 and borrows from the next digit (e.g. 0x10→0x09, 0x100→0x099).
  - Up: increment digit 0. A digit at 9 becomes 0 and carries to the next digit (e.g. 0x09→0x10).
  - Never wraps past the end value, because DONE is entered first.
  - Preset of all zeros in mode 1, or count of zero in mode 0, goes IDLE→DONE on the first press.
- Outputs are registered:
  - running = (state==RUN).
  - done = (state==DONE).
  - expired is a one-cycle registered pulse coincident with the first cycle done=1.
- count and status update on the same posedge as the state change; no combinational path from inputs to outputs.

Test Plan:
- Setup for all scenarios: DIGITS=2, CLK_HZ=10, TICK_HZ=1 (DIV=10).
- Down count with borrow: preset=0x10, mode=0, reset, one press → running=1 after 3 cycles. After 10 further cycles, count=0x09. After 10 more, count=0x08.
- Expiry: preset=0x02, mode=0, press → count 0x01 then 0x00. expired=1 for exactly one cycle with done=1. count stays 0x00 and further presses are ignored.
- Pause/resume phase: run from 0x05, press after 4 prescaler cycles → running=0. Hold 50 cycles with count unchanged. Press → next tick arrives after 6 cycles (not 10).
- Up mode: preset=0x12, mode=1, load → count=0x00. Press → steps through 0x09→0x10→0x11→0x12, then done=1 and expired pulses.
- Clamp and load priority: preset=0x3C, load → count=0x39. In the same cycle assert load and a press → state=IDLE, running=0.
- Reset mid-run: in RUN at count 0x07, reset=0 for one edge → count=preset, IDLE, prescaler=0, expired=0. A held start_n=0 across reset produces no press until it is released and pressed again.
